// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit: FSM states,
// RISC-V load/store funct3 values and error codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: legality/alignment decode, byte enables,
// store-data replication and sign/zero extension of load data.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        illegal,
  output logic        misaligned
);

  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign byte_lane[gi] = rdata_raw[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half
      assign half_lane[gi] = rdata_raw[16*gi +: 16];
    end
  endgenerate

  // Halfword accesses are only extracted once aligned, so addr[1] picks the half.
  assign sel_byte = byte_lane[addr];
  assign sel_half = half_lane[addr[1]];

  always_comb begin
    illegal = 1'b1;
    case (funct3)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_BU, F3_HU:     illegal = we;
      default:          illegal = 1'b1;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (funct3)
      F3_H, F3_HU: misaligned = addr[0];
      F3_W:        misaligned = |addr;
      default:     misaligned = 1'b0;
    endcase
  end

  always_comb begin
    be = 4'b1111;
    if (we) begin
      case (funct3[1:0])
        2'b00:   be = 4'b0001 << addr;
        2'b01:   be = 4'b0011 << addr;
        default: be = 4'b1111;
      endcase
    end
  end

  always_comb begin
    wdata_rep = wdata;
    case (funct3[1:0])
      2'b00:   wdata_rep = {4{wdata[7:0]}};
      2'b01:   wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

  always_comb begin
    rdata_ext = rdata_raw;
    case (funct3)
      F3_B:    rdata_ext = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    rdata_ext = {{16{sel_half[15]}}, sel_half};
      F3_BU:   rdata_ext = {24'd0, sel_byte};
      F3_HU:   rdata_ext = {16'd0, sel_half};
      default: rdata_ext = rdata_raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns a core load/store into a valid/ready bus access,
// stalling the core until the access completes, errors or times out.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_t state_reg, state_next;

  logic [CW-1:0] cnt_reg;
  logic [31:0]   addr_reg;
  logic [3:0]    be_reg;
  logic [31:0]   wdata_reg;
  logic          we_reg;
  logic [2:0]    f3_reg;
  logic [31:0]   rdata_reg;
  logic [1:0]    err_code_reg;

  logic [2:0]  al_funct3;
  logic        al_we;
  logic [1:0]  al_addr;
  logic [3:0]  al_be;
  logic [31:0] al_wdata_rep;
  logic [31:0] al_rdata_ext;
  logic        al_illegal;
  logic        al_misaligned;
  logic        timeout_hit;

  // One align instance serves both phases: live request in IDLE, captured one later.
  assign al_funct3 = (state_reg == IDLE) ? req_funct3    : f3_reg;
  assign al_we     = (state_reg == IDLE) ? req_we        : we_reg;
  assign al_addr   = (state_reg == IDLE) ? req_addr[1:0] : addr_reg[1:0];

  lsu_align u_align (
    .funct3     (al_funct3),
    .we         (al_we),
    .addr       (al_addr),
    .wdata      (req_wdata),
    .rdata_raw  (mem_rdata),
    .be         (al_be),
    .wdata_rep  (al_wdata_rep),
    .rdata_ext  (al_rdata_ext),
    .illegal    (al_illegal),
    .misaligned (al_misaligned)
  );

  assign timeout_hit = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next = (al_illegal || al_misaligned) ? ERR : REQ;
        end
      end
      REQ: begin
        if (mem_ready) begin
          state_next = DONE;
        end else if (timeout_hit) begin
          state_next = ERR;
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg      <= '0;
      addr_reg     <= '0;
      be_reg       <= '0;
      wdata_reg    <= '0;
      we_reg       <= 1'b0;
      f3_reg       <= '0;
      rdata_reg    <= '0;
      err_code_reg <= ERR_NONE;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (req_valid) begin
            if (al_illegal) begin
              err_code_reg <= ERR_ILLEGAL;
            end else if (al_misaligned) begin
              err_code_reg <= ERR_MISALIGN;
            end else begin
              addr_reg     <= req_addr;
              be_reg       <= al_be;
              wdata_reg    <= al_wdata_rep;
              we_reg       <= req_we;
              f3_reg       <= req_funct3;
              err_code_reg <= ERR_NONE;
            end
          end
        end
        REQ: begin
          cnt_reg <= cnt_reg + CW'(1);
          if (mem_ready) begin
            rdata_reg <= we_reg ? 32'd0 : al_rdata_ext;
          end else if (timeout_hit) begin
            err_code_reg <= ERR_TIMEOUT;
          end
        end
        default: cnt_reg <= '0;
      endcase
    end
  end

  always_comb begin
    stall     = 1'b0;
    mem_valid = 1'b0;
    err       = 1'b0;
    err_code  = ERR_NONE;
    rdata     = 32'd0;
    case (state_reg)
      IDLE: stall = req_valid;
      REQ: begin
        stall     = 1'b1;
        mem_valid = 1'b1;
      end
      DONE: rdata = rdata_reg;
      ERR: begin
        err      = 1'b1;
        err_code = err_code_reg;
      end
      default: stall = 1'b0;
    endcase
  end

  assign mem_we    = we_reg;
  assign mem_be    = be_reg;
  assign mem_addr  = {addr_reg[31:2], 2'b00};
  assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized transaction-level bench for lsu_mem_ctrl against an arithmetic
// model of the load/store rules.
module tb_lsu_mem_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        stall;
  logic [31:0] rdata;
  logic        err;
  logic [1:0]  err_code;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  int chk_cnt = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .rdata      (rdata),
    .err        (err),
    .err_code   (err_code),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: what the access should look like from outside.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rd, input int delay,
                       output logic [1:0] e_code, output logic [3:0] e_be,
                       output logic [31:0] e_wd, output logic [31:0] e_rd,
                       output int e_stall, output int e_mv);
    int     size;
    int     off;
    bit     legal;
    bit     signed_ld;
    longint v;
    off       = int'(addr % 4);
    size      = 1 << f3[1:0];
    legal     = we ? (f3 <= 2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    signed_ld = (f3 == 0 || f3 == 1);
    e_be      = we ? 4'(((1 << size) - 1) << off) : 4'hF;
    if (size == 1)      e_wd = (wdata % 256) * 32'h01010101;
    else if (size == 2) e_wd = (wdata % 65536) * 32'h00010001;
    else                e_wd = wdata;
    v = longint'(rd / (32'd1 << (8 * off))) % (64'd1 << (8 * size));
    if (signed_ld && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
    e_rd = we ? 32'd0 : v[31:0];
    if (!legal) begin
      e_code = 2'b11; e_stall = 1; e_mv = 0; e_rd = 0;
    end else if (addr % size != 0) begin
      e_code = 2'b01; e_stall = 1; e_mv = 0; e_rd = 0;
    end else if (delay > TO) begin
      e_code = 2'b10; e_stall = 1 + TO; e_mv = TO; e_rd = 0;
    end else begin
      e_code = 2'b00; e_stall = 1 + delay; e_mv = delay;
    end
  endtask

  // Called and returns at posedge+1; delay = REQ cycle on which mem_ready is raised.
  task automatic run_txn(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rd, input int delay);
    logic [1:0]  e_code;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rd;
    int          e_stall, e_mv, st, mv;
    bit          done;
    model(we, f3, addr, wdata, rd, delay, e_code, e_be, e_wd, e_rd, e_stall, e_mv);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    st = 0; mv = 0; done = 1'b0;
    for (int cyc = 0; cyc < TO + 8 && !done; cyc++) begin
      @(negedge clk);
      if (mem_valid) begin
        mv++;
        check_eq({name, ".be"}, 32'(mem_be), 32'(e_be));
        check_eq({name, ".addr"}, mem_addr, {addr[31:2], 2'b00});
        check_eq({name, ".wdata"}, mem_wdata, e_wd);
        check_eq({name, ".we"}, 32'(mem_we), 32'(we));
        if (mv == delay) begin mem_ready = 1'b1; mem_rdata = rd; end
      end
      if (!stall) begin
        done = 1'b1;
        check_eq({name, ".err"}, 32'(err), 32'(e_code != 2'b00));
        check_eq({name, ".code"}, 32'(err_code), 32'(e_code));
        check_eq({name, ".rdata"}, rdata, e_rd);
      end else begin
        st++;
      end
      if (!done) begin
        @(posedge clk); #1;
        mem_ready = 1'b0; mem_rdata = $urandom;
      end
    end
    if (!done) check_eq({name, ".completion"}, 32'd0, 32'd1);
    check_eq({name, ".stall_cycles"}, st, e_stall);
    check_eq({name, ".valid_cycles"}, mv, e_mv);
    $display("txn %-8s we=%0d f3=%0d addr=0x%08h wdata=0x%08h delay=%0d -> stall=%0d code=%0d rdata=0x%08h",
             name, we, f3, addr, wdata, delay, st, err_code, rdata);
    @(posedge clk); #1;
    req_valid = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check_eq("rst.stall", 32'(stall), 32'd0);
    check_eq("rst.rdata", rdata, 32'd0);
    check_eq("rst.err", 32'(err), 32'd0);
    check_eq("rst.code", 32'(err_code), 32'd0);
    check_eq("rst.valid", 32'(mem_valid), 32'd0);
    check_eq("rst.we", 32'(mem_we), 32'd0);
    check_eq("rst.be", 32'(mem_be), 32'd0);
    check_eq("rst.addr", mem_addr, 32'd0);
    check_eq("rst.wdata", mem_wdata, 32'd0);
    req_valid = 1'b1; #1;
    check_eq("rst.stall_req", 32'(stall), 32'd1);
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Directed cases
    run_txn("sw", 1'b1, 3'b010, 32'h60, 32'h19, $urandom, 1);
    run_txn("sb", 1'b1, 3'b000, 32'h63, 32'hAB, $urandom, 2);
    run_txn("lb", 1'b0, 3'b000, 32'h61, 32'h0, 32'h0000F700, 3);
    run_txn("lbu", 1'b0, 3'b100, 32'h61, 32'h0, 32'h0000F700, 3);
    run_txn("lw_mis", 1'b0, 3'b010, 32'h62, 32'h0, $urandom, 1);
    run_txn("ld_f3_3", 1'b0, 3'b011, 32'h60, 32'h0, $urandom, 1);
    run_txn("sbu_ill", 1'b1, 3'b100, 32'h61, 32'h0, $urandom, 1);
    run_txn("lh_edge", 1'b0, 3'b001, 32'h72, 32'h0, 32'h8001_7FFF, TO);
    run_txn("timeout", 1'b1, 3'b010, 32'h64, 32'hDEAD, $urandom, TO + 1);

    // Late mem_ready while idle must be ignored
    mem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("late_ready.valid", 32'(mem_valid), 32'd0);
      check_eq("late_ready.err", 32'(err), 32'd0);
      check_eq("late_ready.stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;

    // Reset asserted in the middle of a bus access
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h80; req_wdata = 32'h1234;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rstreq.valid_before", 32'(mem_valid), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rstreq.valid_after", 32'(mem_valid), 32'd0);
    check_eq("rstreq.stall", 32'(stall), 32'd1);
    check_eq("rstreq.be", 32'(mem_be), 32'd0);
    req_valid = 1'b0; #1;
    check_eq("rstreq.stall_idle", 32'(stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    run_txn("sw_after", 1'b1, 3'b010, 32'h84, 32'hCAFEF00D, $urandom, 2);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      run_txn("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              32'h100 + 32'($urandom_range(0, 63)), $urandom, $urandom,
              int'($urandom_range(1, TO + 1)));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store unit between the core datapath (ALUResult/WriteData/ReadData path) and a data memory with a valid/ready handshake. It replaces the zero-latency data-memory hookup with a multi-cycle bus access. It also adds byte/halfword/word stores with byte enables and sign/zero-extended loads. It stalls the core while an access is outstanding and reports misaligned, illegal and timed-out accesses.

Parameters:
TIMEOUT, 16, cycles in REQ without mem_ready before aborting with a timeout error (minimum 2).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
req_valid  input  1  core requests a load or store this cycle; held stable while stall=1
req_we  input  1  1=store, 0=load
req_funct3  input  3  RISC-V funct3 of the lw/sw-class instruction
req_addr  input  32  byte address (core ALUResult)
req_wdata  input  32  store data (core WriteData)
stall  output  1  core must hold PC and register writes
rdata  output  32  extended load data (core ReadData)
err  output  1  one-cycle error pulse
err_code  output  2  01 misaligned, 10 timeout, 11 illegal funct3; 00 when err=0
mem_valid  output  1  bus request
mem_ready  input  1  bus completes the access this cycle
mem_we  output  1  bus write
mem_be  output  4  byte enables
mem_addr  output  32  word-aligned address ({req_addr[31:2],2'b00})
mem_wdata  output  32  lane-replicated store data
mem_rdata  input  32  read data, valid when mem_ready & ~mem_we

Behaviour:
- Clock and reset: one clock clk. Reset is synchronous and active-low: when reset=0 at a posedge, state goes to IDLE, the timeout counter clears, and captured registers clear.
- Reset values: stall=0 (unless req_valid), rdata=0, err=0, err_code=00, mem_valid=0, mem_we=0, mem_be=0000, mem_addr=0, mem_wdata=0.
- FSM states: IDLE, REQ, DONE, ERR.
- IDLE:
  - stall = req_valid, combinational.
  - req_valid & legal & aligned -> capture addr, be, wdata, we and funct3, then go to REQ.
  - req_valid & (illegal | misaligned) -> go to ERR; no bus access.
- Legal funct3:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
  - Any other value is illegal. Illegal takes priority over misaligned.
- Alignment:
  - Word accesses require addr[1:0]=00.
  - Half accesses require addr[0]=0.
  - Byte accesses are always aligned.
- REQ:
  - mem_valid=1 and stall=1. mem_* outputs come from registers and are stable for the whole of REQ.
  - mem_ready=1 -> go to DONE. On a load, mem_rdata is extended and registered into rdata.
  - Counter reaches TIMEOUT-1 with mem_ready=0 -> go to ERR with code 10; mem_valid drops on the next cycle.
  - If mem_ready and timeout coincide, mem_ready wins.
- DONE:
  - stall=0 and mem_valid=0. rdata holds the load result; for stores rdata=0.
  - Always goes to IDLE; the core advances at this edge.
  - Minimum access latency: 2 stall cycles (IDLE + REQ), then the DONE cycle.
- ERR:
  - err=1, err_code valid, stall=0, rdata=0.
  - Always goes to IDLE. No register-file write data is meaningful.
- Byte enables: sb = 0001<<addr[1:0]; sh = 0011<<addr[1:0]; sw = 1111. Loads drive be=1111.
- Store data replication: sb = {4{wdata[7:0]}}; sh = {2{wdata[15:0]}}; sw = wdata.
- Load extraction uses the byte/half selected by the captured addr[1:0]:
  - lb/lh sign-extend to 32 bits.
  - lbu/lhu zero-extend.
  - lw passes mem_rdata through.
- req_* inputs are ignored outside IDLE; capture happens only on the IDLE exit.
- mem_ready outside REQ is ignored.
- Reset low during REQ: mem_valid=0 from the next cycle. The bus must tolerate an abandoned request.

Decomposition:
- Package lsu_pkg holds:
  - lsu_state_t enum (IDLE, REQ, DONE, ERR).
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - err codes ERR_NONE, ERR_MISALIGN, ERR_TIMEOUT, ERR_ILLEGAL.
- One combinational sub-module, lsu_align. Inputs: funct3, addr[1:0], wdata, rdata_raw. Outputs: be, wdata_rep, rdata_ext, illegal, misaligned.
- FSM, counter and registers stay in lsu_mem_ctrl.

Test Plan:
- sw addr=0x60 wdata=0x19, mem_ready after 1 cycle -> mem_be=1111, mem_addr=0x60, mem_wdata=0x00000019; stall high exactly 2 cycles; err=0.
- sb addr=0x63 wdata=0xAB -> mem_be=1000, mem_wdata=0xABABABAB.
- lb and lbu addr=0x61 with mem_rdata=0x0000F700, ready after 3 cycles -> lb gives rdata=0xFFFFFFF7 in DONE; lbu gives rdata=0x000000F7; stall high 4 cycles.
- lw addr=0x62 -> no mem_valid; ERR cycle with err=1, err_code=01. funct3=011 -> err_code=11.
- TIMEOUT=4, mem_ready held 0 -> mem_valid high 4 cycles, then err_code=10. A mem_ready raised afterwards is ignored.
- reset=0 during REQ -> next cycle mem_valid=0, stall=req_valid, state IDLE; a following sw completes normally.
